uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 45 ++++
 rtl/uart_sched_fifo.sv | 56 +++++
 rtl/uart_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_scheduler_pkg : FSM states, UART status bits and register map.
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------

`ifndef UART_DATA
`define UART_DATA    32'h4000_0000
`endif
`ifndef UART_STATUS
`define UART_STATUS  32'h4000_0004
`endif
`ifndef UART_CONTROL
`define UART_CONTROL 32'h4000_0008
`endif
`ifndef UART_BAUD
`define UART_BAUD    32'h4000_000C
`endif

package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_INIT_BAUD = 3'd0,
    ST_INIT_CTRL = 3'd1,
    ST_IDLE      = 3'd2,
    ST_POLL      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_SETTLE    = 3'd5
  } sched_state_e;

  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_FULL_BIT  = 0;

  // Favour the requester that was not served last when both are pending.
  function automatic logic rr_pick(input logic [1:0] pending, input logic last);
    if (pending[0] && pending[1]) begin
      return ~last;
    end
    return pending[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sched_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sched_fifo : synchronous pointer-based 8-bit FIFO, one per requester.
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------

module uart_sched_fifo
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]     mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_scheduler : arbitrates two byte requesters onto a UART register bus.
// Optional per-requester FIFOs enabled by UART_SCHED_FIFO_EN.
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------

module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV      = 16'd434,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_wdata,
  output logic        uart_we,
  output logic        uart_re,
  input  logic [31:0] uart_rdata,
  output logic        sched_busy
);

  logic [1:0] w_req_valid;
  logic [1:0] w_req_ready;
  logic [1:0] w_room;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_pending;
  logic [7:0] w_req_data [2];
  logic [7:0] w_head     [2];

  sched_state_e state_q, state_d;
  logic         grant_q, grant_d;
  logic         last_q,  last_d;
  logic [15:0]  settle_q, settle_d;

  assign w_req_valid   = {req1_valid, req0_valid};
  assign w_req_data[0] = req0_data;
  assign w_req_data[1] = req1_data;
  assign w_req_ready   = w_room & {2{~rst}};
  assign w_push        = w_req_valid & w_req_ready;
  assign req0_ready    = w_req_ready[0];
  assign req1_ready    = w_req_ready[1];

`ifdef UART_SCHED_FIFO_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic w_empty;
    logic w_full;

    uart_sched_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push[gi]),
      .data_i  (w_req_data[gi]),
      .pop_i   (w_pop[gi]),
      .data_o  (w_head[gi]),
      .empty_o (w_empty),
      .full_o  (w_full)
    );

    assign w_pending[gi] = ~w_empty;
    assign w_room[gi]    = ~w_full;
  end
`else
  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    logic       full_q;
    logic [7:0] data_q;

    // Ready is low while full, so push and pop never coincide.
    always_ff @(posedge clk) begin
      if (rst) begin
        full_q <= 1'b0;
        data_q <= 8'h00;
      end else if (w_push[gi]) begin
        full_q <= 1'b1;
        data_q <= w_req_data[gi];
      end else if (w_pop[gi]) begin
        full_q <= 1'b0;
      end
    end

    assign w_pending[gi] = full_q;
    assign w_room[gi]    = ~full_q;
    assign w_head[gi]    = data_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT_BAUD;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    settle_d   = settle_q;
    w_pop      = 2'b00;
    uart_addr  = 32'h0;
    uart_wdata = 32'h0;
    uart_we    = 1'b0;
    uart_re    = 1'b0;

    unique case (state_q)
      ST_INIT_BAUD: begin
        uart_we    = 1'b1;
        uart_addr  = `UART_BAUD;
        uart_wdata = {16'b0, BAUD_DIV};
        state_d    = ST_INIT_CTRL;
      end
      ST_INIT_CTRL: begin
        uart_we    = 1'b1;
        uart_addr  = `UART_CONTROL;
        uart_wdata = 32'h1;
        state_d    = ST_IDLE;
      end
      ST_IDLE: begin
        if (|w_pending) begin
          grant_d = rr_pick(w_pending, last_q);
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        uart_re   = 1'b1;
        uart_addr = `UART_STATUS;
        if (!uart_rdata[STATUS_BUSY_BIT]) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        uart_we        = 1'b1;
        uart_addr      = `UART_DATA;
        uart_wdata     = {24'b0, w_head[grant_q]};
        w_pop[grant_q] = 1'b1;
        last_d         = grant_q;
        settle_d       = '0;
        state_d        = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_IDLE;
      end
      ST_SETTLE: begin
        // Gives the UART busy flag time to rise before the next poll.
        if (settle_q >= 16'(SETTLE_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_INIT_BAUD;
      end
    endcase

    if (rst) begin
      w_pop      = 2'b00;
      uart_addr  = 32'h0;
      uart_wdata = 32'h0;
      uart_we    = 1'b0;
      uart_re    = 1'b0;
    end
  end

  assign sched_busy = ~rst & ((state_q != ST_IDLE) | (|w_pending));

  logic w_unused;
  assign w_unused = ^{uart_rdata[31:3], uart_rdata[STATUS_EMPTY_BIT],
                      uart_rdata[STATUS_FULL_BIT], 32'(FIFO_DEPTH)};

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler : scoreboard bench for uart_tx_scheduler.
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------

module tb_uart_tx_scheduler;

  localparam logic [31:0] A_DATA    = 32'h4000_0000;
  localparam logic [31:0] A_STATUS  = 32'h4000_0004;
  localparam logic [31:0] A_CONTROL = 32'h4000_0008;
  localparam logic [31:0] A_BAUD    = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data  = 8'h00;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data  = 8'h00;
  logic        req1_ready;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_we;
  logic        uart_re;
  logic [31:0] uart_rdata = 32'h0;
  logic        sched_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int data_writes = 0;
  int last_accept_edge = 0;
  int last_write_edge = 0;
  logic [7:0] exp_q [$];

  uart_tx_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_we    (uart_we),
    .uart_re    (uart_re),
    .uart_rdata (uart_rdata),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: pushes on accepted handshakes, pops on UART_DATA writes.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        exp_q.push_back(req0_data);
        last_accept_edge = cyc + 1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(req1_data);
      end
      if (uart_we || uart_re) begin
        chk("we_re_exclusive", {31'b0, uart_we & uart_re}, 32'd0);
      end
      if (uart_we && uart_addr == A_DATA) begin
        data_writes++;
        last_write_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_data_write", 32'd1, 32'd0);
        end else begin
          chk("data_byte", uart_wdata, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    uart_rdata = 32'h0;
    tick();
    @(negedge clk);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
    chk("rst_we",     {31'b0, uart_we}, 32'd0);
    chk("rst_re",     {31'b0, uart_re}, 32'd0);
    chk("rst_addr",   uart_addr, 32'd0);
    chk("rst_busy",   {31'b0, sched_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("baud_we",   {31'b0, uart_we}, 32'd1);
    chk("baud_addr", uart_addr, A_BAUD);
    chk("baud_data", uart_wdata, 32'h0000_01B2);
    @(negedge clk);
    chk("ctrl_we",   {31'b0, uart_we}, 32'd1);
    chk("ctrl_addr", uart_addr, A_CONTROL);
    chk("ctrl_data", uart_wdata, 32'h1);
    @(negedge clk);
    chk("idle_bus",    {uart_addr[30:0], uart_we | uart_re}, 32'd0);
    chk("idle_busy",   {31'b0, sched_busy}, 32'd0);
    chk("idle_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] b);
    int guard;
    guard      = 0;
    req0_data  = b;
    req0_valid = 1'b1;
    @(negedge clk);
    while (!req0_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send0_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (data_writes >= target) break;
      tick();
    end
    chk("write_count", data_writes >= target, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !sched_busy) break;
      tick();
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    int saved;

    do_reset();

    // Single byte, UART idle: fixed acceptance-to-write latency.
    send0(8'h41);
    wait_drain(50);
    chk("latency_cycles", last_write_edge - last_accept_edge, 32'd3);

    // Both requesters pending continuously: strict alternation from req0.
    do_reset();
    saved      = data_writes;
    req0_data  = 8'h55;
    req1_data  = 8'hAA;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_writes(saved + 6, 200);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain(100);

    // UART busy for 10 cycles: polling continues, write follows busy clear.
    uart_rdata = 32'h4;
    saved = data_writes;
    send0(8'h33);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_poll_re",   {31'b0, uart_re}, 32'd1);
      chk("busy_poll_addr", uart_addr, A_STATUS);
      chk("busy_no_write",  data_writes, saved);
      tick();
    end
    uart_rdata = 32'h0;
    @(negedge clk);
    chk("clear_poll_re", {31'b0, uart_re}, 32'd1);
    @(negedge clk);
    chk("clear_write_we",   {31'b0, uart_we}, 32'd1);
    chk("clear_write_addr", uart_addr, A_DATA);
    chk("clear_write_data", uart_wdata, 32'h33);
`ifndef UART_SCHED_FIFO_EN
    chk("write_ready0_low", {31'b0, req0_ready}, 32'd0);
    @(negedge clk);
    chk("post_write_ready0", {31'b0, req0_ready}, 32'd1);
`endif
    wait_drain(50);

    // Reset during POLL discards the held byte and re-runs init.
    uart_rdata = 32'h4;
    saved = data_writes;
    send0(8'h77);
    tick();
    @(negedge clk);
    chk("abort_in_poll", {31'b0, uart_re}, 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_data", data_writes, saved);
    chk("abort_idle", {31'b0, sched_busy}, 32'd0);

`ifndef UART_SCHED_FIFO_EN
    // One-entry holding register: ready low while a byte waits.
    uart_rdata = 32'h4;
    saved = data_writes;
    send0(8'h11);
    req0_data  = 8'h22;
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_ready0_low", {31'b0, req0_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    uart_rdata = 32'h0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (data_writes >= saved + 2) break;
    end
    req0_valid = 1'b0;
    chk("hold_two_writes", data_writes >= saved + 2, 32'd1);
    wait_drain(50);
`else
    // FIFO build: four pushes fill the FIFO, then drain in order.
    do_reset();
    uart_rdata = 32'h4;
    for (int i = 1; i <= 4; i++) begin
      req0_data  = 8'(i);
      req0_valid = 1'b1;
      @(negedge clk);
      chk("fifo_ready_high", {31'b0, req0_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    req0_data = 8'h05;
    @(negedge clk);
    chk("fifo_full_ready", {31'b0, req0_ready}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    uart_rdata = 32'h0;
    wait_drain(200);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
